// File: rtl/arp_status_regs.sv
// ARP RX status block: header shadow registers, per-type and drop counters, sticky flags and a snapshot lock behind a registered read port.
// Defining ARP_STATUS_RDCLR_EN makes counter reads destructive (clear-on-read).
module arp_status_regs #(
    parameter int          NUM_TYPES    = 4,
    parameter int          CNT_W        = 32,
    parameter int          LOCK_TIMEOUT = 1024,
    parameter logic [15:0] VERSION      = 16'h0102
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_cmd_addr,
    input  logic        i_rx_pkt_rd,
    output logic [31:0] o_rx_pkt_data,
    output logic        o_rx_pkt_vld,
    input  logic        i_pkt_valid,
    input  logic [47:0] i_dst_mac,
    input  logic [47:0] i_src_mac,
    input  logic [1:0]  i_operation,
    input  logic [47:0] i_SHA,
    input  logic [31:0] i_SPA,
    input  logic [47:0] i_THA,
    input  logic [31:0] i_TPA,
    input  logic [1:0]  i_packet_type,
    input  logic        i_clr_stats
);

    localparam logic [7:0] ADDR_VERSION  = 8'h00;
    localparam logic [7:0] ADDR_DST_LO   = 8'h01;
    localparam logic [7:0] ADDR_DST_HI   = 8'h02;
    localparam logic [7:0] ADDR_SRC_LO   = 8'h03;
    localparam logic [7:0] ADDR_SRC_HI   = 8'h04;
    localparam logic [7:0] ADDR_OPER     = 8'h05;
    localparam logic [7:0] ADDR_SHA_LO   = 8'h06;
    localparam logic [7:0] ADDR_SHA_HI   = 8'h07;
    localparam logic [7:0] ADDR_SPA      = 8'h08;
    localparam logic [7:0] ADDR_THA_LO   = 8'h09;
    localparam logic [7:0] ADDR_THA_HI   = 8'h0A;
    localparam logic [7:0] ADDR_TPA      = 8'h0B;
    localparam logic [7:0] ADDR_STATUS   = 8'h0C;
    localparam logic [7:0] ADDR_CNT_BASE = 8'h10;
    localparam logic [7:0] ADDR_DROP     = 8'h14;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int TMO_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e      state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [47:0] dst_mac_q, dst_mac_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [1:0]  oper_q, oper_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [47:0] tha_q, tha_d;
    logic [31:0] tpa_q, tpa_d;
    logic        snap_valid_q, snap_valid_d;
    logic        drop_sticky_q, drop_sticky_d;

    logic [CNT_W-1:0]     type_cnt_q [NUM_TYPES];
    logic [CNT_W-1:0]     type_cnt_d [NUM_TYPES];
    logic [NUM_TYPES-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;
    logic [31:0] rd_mux;

    logic                 locked;
    logic                 rd_lock;
    logic                 rd_unlock;
    logic                 capture;
    logic                 drop;
    logic [NUM_TYPES-1:0] type_inc;
    logic [NUM_TYPES-1:0] type_rdclr;
    logic                 drop_rdclr;
    logic [3:0]           ovf_rd;

    assign locked    = (state_q == ST_LOCKED);
    assign rd_lock   = i_rx_pkt_rd && (i_rx_cmd_addr == ADDR_DST_LO);
    assign rd_unlock = i_rx_pkt_rd && (i_rx_cmd_addr == ADDR_TPA);
    // A lock request in the same cycle as a packet freezes the old snapshot.
    assign capture   = i_pkt_valid && !locked && !rd_lock;
    assign drop      = i_pkt_valid && !capture;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TYPES; gi++) begin : g_type
            assign type_inc[gi] = i_pkt_valid && (i_packet_type == 2'(gi));
`ifdef ARP_STATUS_RDCLR_EN
            assign type_rdclr[gi] = i_rx_pkt_rd && (i_rx_cmd_addr == ADDR_CNT_BASE + 8'(gi));
`else
            assign type_rdclr[gi] = 1'b0;
`endif
        end
        for (gi = 0; gi < 4; gi++) begin : g_ovf_rd
            if (gi < NUM_TYPES) begin : g_live
                assign ovf_rd[gi] = ovf_q[gi];
            end else begin : g_tied
                assign ovf_rd[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef ARP_STATUS_RDCLR_EN
    assign drop_rdclr = i_rx_pkt_rd && (i_rx_cmd_addr == ADDR_DROP);
`else
    assign drop_rdclr = 1'b0;
`endif

    // Saturating increment applied on top of an optional clear-on-read.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                    input logic             rd_clr,
                                                    input logic             inc);
        logic [CNT_W-1:0] base;
        base = rd_clr ? '0 : cur;
        if (inc && (base != CNT_MAX)) begin
            base = base + CNT_W'(1);
        end
        return base;
    endfunction

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_UNLOCKED: begin
                tmo_d = '0;
                if (rd_lock) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (i_rx_pkt_rd) begin
                    tmo_d = '0;
                    if (rd_unlock) begin
                        state_d = ST_UNLOCKED;
                    end
                end else if (LOCK_TIMEOUT != 0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_UNLOCKED;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                tmo_d   = '0;
            end
        endcase
    end

    always_comb begin
        dst_mac_d     = dst_mac_q;
        src_mac_d     = src_mac_q;
        oper_d        = oper_q;
        sha_d         = sha_q;
        spa_d         = spa_q;
        tha_d         = tha_q;
        tpa_d         = tpa_q;
        snap_valid_d  = snap_valid_q;
        drop_sticky_d = drop_sticky_q;
        if (capture) begin
            dst_mac_d    = i_dst_mac;
            src_mac_d    = i_src_mac;
            oper_d       = i_operation;
            sha_d        = i_SHA;
            spa_d        = i_SPA;
            tha_d        = i_THA;
            tpa_d        = i_TPA;
            snap_valid_d = 1'b1;
        end
        if (drop) begin
            drop_sticky_d = 1'b1;
        end
        if (i_clr_stats) begin
            snap_valid_d  = 1'b0;
            drop_sticky_d = 1'b0;
        end
    end

    // Packet-type counting is independent of whether the header was captured.
    always_comb begin
        for (int t = 0; t < NUM_TYPES; t++) begin
            type_cnt_d[t] = next_count(type_cnt_q[t], type_rdclr[t], type_inc[t]);
            ovf_d[t]      = (ovf_q[t] && !type_rdclr[t]) ||
                            (type_inc[t] && (type_cnt_d[t] == CNT_MAX));
            if (i_clr_stats) begin
                type_cnt_d[t] = '0;
                ovf_d[t]      = 1'b0;
            end
        end
        drop_cnt_d = next_count(drop_cnt_q, drop_rdclr, drop);
        if (i_clr_stats) begin
            drop_cnt_d = '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (i_rx_cmd_addr)
            ADDR_VERSION: rd_mux = {16'd0, VERSION};
            ADDR_DST_LO:  rd_mux = dst_mac_q[31:0];
            ADDR_DST_HI:  rd_mux = {16'd0, dst_mac_q[47:32]};
            ADDR_SRC_LO:  rd_mux = src_mac_q[31:0];
            ADDR_SRC_HI:  rd_mux = {16'd0, src_mac_q[47:32]};
            ADDR_OPER:    rd_mux = {30'd0, oper_q};
            ADDR_SHA_LO:  rd_mux = sha_q[31:0];
            ADDR_SHA_HI:  rd_mux = {16'd0, sha_q[47:32]};
            ADDR_SPA:     rd_mux = spa_q;
            ADDR_THA_LO:  rd_mux = tha_q[31:0];
            ADDR_THA_HI:  rd_mux = {16'd0, tha_q[47:32]};
            ADDR_TPA:     rd_mux = tpa_q;
            ADDR_STATUS:  rd_mux = {24'd0, ovf_rd, 1'b0, drop_sticky_q, locked, snap_valid_q};
            ADDR_DROP:    rd_mux = 32'(drop_cnt_q);
            default:      rd_mux = '0;
        endcase
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (i_rx_cmd_addr == ADDR_CNT_BASE + 8'(t)) begin
                rd_mux = 32'(type_cnt_q[t]);
            end
        end
    end

    always_comb begin
        rd_vld_d  = i_rx_pkt_rd;
        rd_data_d = i_rx_pkt_rd ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_UNLOCKED;
            tmo_q         <= '0;
            dst_mac_q     <= '0;
            src_mac_q     <= '0;
            oper_q        <= '0;
            sha_q         <= '0;
            spa_q         <= '0;
            tha_q         <= '0;
            tpa_q         <= '0;
            snap_valid_q  <= 1'b0;
            drop_sticky_q <= 1'b0;
            for (int t = 0; t < NUM_TYPES; t++) begin
                type_cnt_q[t] <= '0;
            end
            ovf_q         <= '0;
            drop_cnt_q    <= '0;
            rd_data_q     <= '0;
            rd_vld_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            dst_mac_q     <= dst_mac_d;
            src_mac_q     <= src_mac_d;
            oper_q        <= oper_d;
            sha_q         <= sha_d;
            spa_q         <= spa_d;
            tha_q         <= tha_d;
            tpa_q         <= tpa_d;
            snap_valid_q  <= snap_valid_d;
            drop_sticky_q <= drop_sticky_d;
            for (int t = 0; t < NUM_TYPES; t++) begin
                type_cnt_q[t] <= type_cnt_d[t];
            end
            ovf_q         <= ovf_d;
            drop_cnt_q    <= drop_cnt_d;
            rd_data_q     <= rd_data_d;
            rd_vld_q      <= rd_vld_d;
        end
    end

    assign o_rx_pkt_data = rd_data_q;
    assign o_rx_pkt_vld  = rd_vld_q;

endmodule

// File: tb/tb_arp_status_regs.sv
// Self-checking bench for arp_status_regs: directed vector table, hand-written lock/timeout/saturation
// sequences and a randomized phase checked against a behavioural model (NUM_TYPES=3, CNT_W=8, LOCK_TIMEOUT=16).
module tb_arp_status_regs;

    localparam int          NT   = 3;
    localparam int          CW   = 8;
    localparam int          LT   = 16;
    localparam logic [15:0] VER  = 16'h0102;
    localparam int          CMAX = (1 << CW) - 1;
`ifdef ARP_STATUS_RDCLR_EN
    localparam bit RDCLR = 1'b1;
`else
    localparam bit RDCLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_cmd_addr = '0;
    logic        rx_pkt_rd = 1'b0;
    logic [31:0] rx_pkt_data;
    logic        rx_pkt_vld;
    logic        pkt_valid = 1'b0;
    logic [47:0] dst_mac = '0, src_mac = '0, sha = '0, tha = '0;
    logic [1:0]  operation = '0, packet_type = '0;
    logic [31:0] spa = '0, tpa = '0;
    logic        clr_stats = 1'b0;

    always #5 clk = ~clk;

    arp_status_regs #(
        .NUM_TYPES(NT), .CNT_W(CW), .LOCK_TIMEOUT(LT), .VERSION(VER)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rx_cmd_addr(rx_cmd_addr), .i_rx_pkt_rd(rx_pkt_rd),
        .o_rx_pkt_data(rx_pkt_data), .o_rx_pkt_vld(rx_pkt_vld),
        .i_pkt_valid(pkt_valid), .i_dst_mac(dst_mac), .i_src_mac(src_mac),
        .i_operation(operation), .i_SHA(sha), .i_SPA(spa), .i_THA(tha), .i_TPA(tpa),
        .i_packet_type(packet_type), .i_clr_stats(clr_stats)
    );

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        logic        pv;
        logic [1:0]  ptype;
        logic [31:0] spa;
        logic [31:0] tpa;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [47:0] m_dst, m_src, m_sha, m_tha;
    logic [31:0] m_spa, m_tpa;
    logic [1:0]  m_op;
    int          m_cnt[4];
    bit          m_ovf[4];
    int          m_drop;
    bit          m_sticky, m_snap, m_lk;
    int          m_last;
    int          cyc = 0;
    logic [31:0] last_data;

    // Values driven on the non-SHA/SPA/TPA header inputs
    logic [47:0] nx_dst = 48'hAABB_CCDD_EEFF;
    logic [47:0] nx_src = 48'h1122_3344_5566;
    logic [47:0] nx_tha = 48'h6677_8899_AABB;
    logic [1:0]  nx_op  = 2'd2;

    int n_vec = 0;
    int n_bad = 0;

    task automatic m_reset();
        m_dst = '0; m_src = '0; m_sha = '0; m_tha = '0;
        m_spa = '0; m_tpa = '0; m_op = '0;
        for (int t = 0; t < 4; t++) begin
            m_cnt[t] = 0;
            m_ovf[t] = 1'b0;
        end
        m_drop = 0; m_sticky = 1'b0; m_snap = 1'b0; m_lk = 1'b0; m_last = 0;
        last_data = '0;
    endtask

    // Locked means: lock taken and no more than LT cycles since the last read made while locked.
    function automatic bit m_locked();
        return m_lk && ((LT == 0) || ((cyc - m_last) <= LT));
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [3:0] ov;
        int idx;
        ov = '0;
        for (int t = 0; t < NT; t++) ov[t] = m_ovf[t];
        idx = int'(a) - 16;
        case (a)
            8'h00: return {16'd0, VER};
            8'h01: return m_dst[31:0];
            8'h02: return {16'd0, m_dst[47:32]};
            8'h03: return m_src[31:0];
            8'h04: return {16'd0, m_src[47:32]};
            8'h05: return {30'd0, m_op};
            8'h06: return m_sha[31:0];
            8'h07: return {16'd0, m_sha[47:32]};
            8'h08: return m_spa;
            8'h09: return m_tha[31:0];
            8'h0A: return {16'd0, m_tha[47:32]};
            8'h0B: return m_tpa;
            8'h0C: return {24'd0, ov, 1'b0, m_sticky, m_locked(), m_snap};
            8'h10, 8'h11, 8'h12, 8'h13: return (idx < NT) ? 32'(m_cnt[idx]) : 32'd0;
            8'h14: return 32'(m_drop);
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_update(input logic r, input logic [7:0] a, input logic pv, input logic [1:0] pt,
                            input logic [47:0] s_sha, input logic [31:0] s_spa, input logic [31:0] s_tpa,
                            input logic clr);
        bit lkd, lock_rd, cap, drp;
        lkd     = m_locked();
        lock_rd = r && (a == 8'h01);
        cap     = pv && !lkd && !lock_rd;
        drp     = pv && !cap;
        if (cap) begin
            m_dst = nx_dst; m_src = nx_src; m_op = nx_op; m_sha = s_sha;
            m_spa = s_spa; m_tha = nx_tha; m_tpa = s_tpa; m_snap = 1'b1;
        end
        if (drp) m_sticky = 1'b1;
        if (RDCLR && r) begin
            for (int t = 0; t < NT; t++) begin
                if (int'(a) == 16 + t) begin
                    m_cnt[t] = 0;
                    m_ovf[t] = 1'b0;
                end
            end
            if (a == 8'h14) m_drop = 0;
        end
        if (pv && (int'(pt) < NT) && (m_cnt[pt] < CMAX)) begin
            m_cnt[pt] = m_cnt[pt] + 1;
            if (m_cnt[pt] == CMAX) m_ovf[pt] = 1'b1;
        end
        if (drp && (m_drop < CMAX)) m_drop = m_drop + 1;
        if (clr) begin
            for (int t = 0; t < 4; t++) begin
                m_cnt[t] = 0;
                m_ovf[t] = 1'b0;
            end
            m_drop = 0; m_sticky = 1'b0; m_snap = 1'b0;
        end
        if (lkd) begin
            if (r) begin
                m_last = cyc;
                if (a == 8'h0B) m_lk = 1'b0;
            end
        end else begin
            m_lk = 1'b0;
            if (lock_rd) begin
                m_lk   = 1'b1;
                m_last = cyc;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", nm, got, exp);
        end
    endtask

    // One clock of stimulus; every cycle is checked against the model.
    task automatic step(input logic r, input logic [7:0] a, input logic pv, input logic [1:0] pt,
                        input logic [47:0] s_sha, input logic [31:0] s_spa, input logic [31:0] s_tpa,
                        input logic clr, output logic [31:0] got);
        logic [31:0] exp;
        rx_pkt_rd = r; rx_cmd_addr = a; pkt_valid = pv; packet_type = pt;
        sha = s_sha; spa = s_spa; tpa = s_tpa; clr_stats = clr;
        dst_mac = nx_dst; src_mac = nx_src; tha = nx_tha; operation = nx_op;
        exp = r ? m_read(a) : last_data;
        @(posedge clk);
        #1;
        got = rx_pkt_data;
        check("vld", {31'd0, rx_pkt_vld}, {31'd0, r});
        check(r ? $sformatf("rd%02h", a) : "hold", got, exp);
        if (r) $display("rd addr=%02h data=%08h", a, got);
        last_data = exp;
        m_update(r, a, pv, pt, s_sha, s_spa, s_tpa, clr);
        cyc++;
    endtask

    task automatic idle();
        logic [31:0] g;
        step(1'b0, 8'h00, 1'b0, 2'd0, '0, '0, '0, 1'b0, g);
    endtask

    task automatic rd_only(input logic [7:0] a, output logic [31:0] g);
        step(1'b1, a, 1'b0, 2'd0, '0, '0, '0, 1'b0, g);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] e, input string nm);
        logic [31:0] g;
        rd_only(a, g);
        check(nm, g, e);
    endtask

    task automatic pkt(input logic [1:0] pt, input logic [31:0] s_spa);
        logic [31:0] g;
        step(1'b0, 8'h00, 1'b1, pt, 48'h0011_2233_4455, s_spa, {16'hC0A8, s_spa[15:0]}, 1'b0, g);
    endtask

    task automatic clr_pulse();
        logic [31:0] g;
        step(1'b0, 8'h00, 1'b0, 2'd0, '0, '0, '0, 1'b1, g);
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] a, input logic pv, input logic [1:0] pt,
                                input logic [31:0] s_spa, input logic [31:0] s_tpa,
                                input logic chk, input logic [31:0] e);
        vec_t v;
        v.rd = r; v.addr = a; v.pv = pv; v.ptype = pt; v.spa = s_spa; v.tpa = s_tpa;
        v.chk = chk; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [31:0] g;
        int          prob;
        logic        r, pv, clr;
        logic [7:0]  a;
        m_reset();

        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1, 32'h0000_0102));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 32'h0A00_0001, 32'hC0A8_0001, 0, 32'h0));
        vecs.push_back(mk(1, 8'h06, 0, 0, 0, 0, 1, 32'h2233_4455));
        vecs.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 32'h0000_0011));
        vecs.push_back(mk(1, 8'h0B, 0, 0, 0, 0, 1, 32'hC0A8_0001));
        vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0, 1, 32'h1));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0, 0, 1, 32'h1));
        vecs.push_back(mk(1, 8'h01, 0, 0, 0, 0, 1, 32'hCCDD_EEFF));
        vecs.push_back(mk(0, 8'h00, 1, 0, 32'h0A00_0002, 32'hC0A8_0002, 0, 32'h0));
        vecs.push_back(mk(1, 8'h08, 0, 0, 0, 0, 1, 32'h0A00_0001));
        vecs.push_back(mk(1, 8'h14, 0, 0, 0, 0, 1, 32'h1));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0, 0, 1, 32'h7));
        vecs.push_back(mk(1, 8'h0B, 0, 0, 0, 0, 1, 32'hC0A8_0001));
        vecs.push_back(mk(0, 8'h00, 1, 0, 32'h0A00_0002, 32'hC0A8_0002, 0, 32'h0));
        vecs.push_back(mk(1, 8'h08, 0, 0, 0, 0, 1, 32'h0A00_0002));
        vecs.push_back(mk(1, 8'h10, 0, 0, 0, 0, 1, 32'h2));
        vecs.push_back(mk(1, 8'h13, 0, 0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 8'h00, 1, 3, 32'h0A00_0004, 32'hC0A8_0004, 0, 32'h0));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0, 0, 1, 32'h5));
        vecs.push_back(mk(1, 8'h0D, 0, 0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(1, 8'h01, 1, 1, 32'h0A00_0005, 32'hC0A8_0005, 1, 32'hCCDD_EEFF));
        vecs.push_back(mk(1, 8'h08, 0, 0, 0, 0, 1, 32'h0A00_0004));
        vecs.push_back(mk(1, 8'h0B, 1, 0, 32'h0A00_0006, 32'hC0A8_0006, 1, 32'hC0A8_0004));
        vecs.push_back(mk(1, 8'h08, 0, 0, 0, 0, 1, 32'h0A00_0004));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0, 0, 1, 32'h5));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", {31'd0, rx_pkt_vld}, 32'd0);
        check("rst_data", rx_pkt_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].rd, vecs[i].addr, vecs[i].pv, vecs[i].ptype, 48'h0011_2233_4455,
                 vecs[i].spa, vecs[i].tpa, 1'b0, g);
            if (vecs[i].chk) check($sformatf("vec%0d", i), g, vecs[i].exp);
        end

        // Lock timeout: after LT idle cycles the next packet is captured
        rd_only(8'h01, g);
        repeat (LT) idle();
        pkt(2'd0, 32'h0A00_00AA);
        rd_chk(8'h08, 32'h0A00_00AA, "tmo_capture");
        rd_only(8'h0C, g);
        check("tmo_lockbit", {31'd0, g[1]}, 32'd0);
        rd_only(8'h14, g);
        // One cycle short of the timeout the lock still holds
        rd_only(8'h01, g);
        repeat (LT - 1) idle();
        pkt(2'd0, 32'h0A00_00BB);
        rd_chk(8'h08, 32'h0A00_00AA, "tmo_edge_drop");
        rd_only(8'h0B, g);

        // Type-2 counter saturation and clear
        clr_pulse();
        repeat (256) pkt(2'd2, 32'h0A00_0100);
        rd_only(8'h0C, g);
        check("sat_ovf2", {31'd0, g[6]}, 32'd1);
        rd_chk(8'h12, 32'd255, "sat_cnt2");
        clr_pulse();
        rd_chk(8'h12, 32'd0, "clr_cnt2");
        rd_chk(8'h0C, 32'd0, "clr_status");

        // Counter read semantics
        repeat (3) pkt(2'd0, 32'h0A00_0200);
        rd_chk(8'h10, 32'd3, "cnt0_first");
        rd_chk(8'h10, RDCLR ? 32'd0 : 32'd3, "cnt0_second");
        step(1'b1, 8'h10, 1'b1, 2'd0, '0, 32'h0A00_0201, 32'hC0A8_0201, 1'b0, g);
        check("cnt0_rd_inc", g, RDCLR ? 32'd0 : 32'd3);
        rd_chk(8'h10, RDCLR ? 32'd1 : 32'd4, "cnt0_after_inc");
        // Clear beats a same-cycle increment
        step(1'b0, 8'h00, 1'b1, 2'd1, '0, 32'h0A00_0300, 32'hC0A8_0300, 1'b1, g);
        rd_chk(8'h11, 32'd0, "clr_prio");

        // Randomized phases: busy reads, then sparse reads so the timeout fires
        for (int ph = 0; ph < 2; ph++) begin
            prob = (ph == 0) ? 45 : 4;
            for (int i = 0; i < 2000; i++) begin
                r   = ($urandom_range(99) < prob);
                case ($urandom_range(4))
                    0:       a = 8'h01;
                    1:       a = 8'h0B;
                    default: a = 8'($urandom_range(22));
                endcase
                pv  = ($urandom_range(99) < 30);
                clr = ($urandom_range(63) == 0);
                nx_dst = 48'({$urandom(), $urandom()});
                nx_src = 48'({$urandom(), $urandom()});
                nx_tha = 48'({$urandom(), $urandom()});
                nx_op  = 2'($urandom_range(3));
                step(r, a, pv, 2'($urandom_range(3)), 48'({$urandom(), $urandom()}),
                     $urandom(), $urandom(), clr, g);
            end
        end

        // Reset asserted while a read is pending
        rx_pkt_rd = 1'b1; rx_cmd_addr = 8'h00; pkt_valid = 1'b0; clr_stats = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_vld", {31'd0, rx_pkt_vld}, 32'd0);
        check("midrst_data", rx_pkt_data, 32'd0);
        rx_pkt_rd = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_chk(8'h00, 32'h0000_0102, "post_rst_ver");
        rd_chk(8'h0C, 32'd0, "post_rst_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
